uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//  - Serialises one byte per request into a standard 8N1-style UART frame on a single line.
//  - Frame order: start bit (0), data LSB-first, stop bit(s) (1).
//  - Transmit-side counterpart to the receive path, with the same clocking and baud timing model.
//  - Driven by a host through a valid/ready handshake; tx drives the pad or the loopback line.
// PARAMETERS
//  - CLKS_PER_BIT  default 16  clk cycles per serial bit period; legal range >= 2
//  - DATA_BITS     default 8   data bits per frame; legal range 5..8
//  - STOP_BITS     default 1   stop bits per frame; legal values 1 or 2
// PORTS
//  - clk       in   1          system clock; all logic on rising edge
//  - reset     in   1          synchronous, active-high reset
//  - tx_data   in   DATA_BITS  byte to send; sampled only on an accept edge
//  - tx_valid  in   1          host has tx_data available
//  - tx_ready  out  1          block can accept a byte (high only in IDLE)
//  - tx        out  1          serial line; idle level is 1
//  - busy      out  1          frame in progress (~tx_ready)
//  - baud      out  1          one-cycle pulse at each bit-period boundary, for debug/bench
// BEHAVIOUR
//  - Reset values: tx=1, tx_ready=1, busy=0, baud=0, state=IDLE.
//    Reset also clears shift register, bit counter and baud counter.
//  - Accept: rising edge with tx_valid && tx_ready.
//    On that edge, tx_data is loaded into the shift register, state goes to START and the baud counter clears.
//  - Start bit: tx=0 from the cycle after accept. Latency from accept edge to start bit is 1 cycle.
//  - Bit timing: the baud counter counts 0..CLKS_PER_BIT-1.
//    At terminal count, baud pulses for 1 cycle and the state/bit advances.
//    The counter is frame-aligned: it restarts on accept and does not free-run.
//  - States:
//    - IDLE: tx=1. Go to START on accept.
//    - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
//    - DATA: tx=shreg[0]; shift right at each baud pulse.
//      After bit DATA_BITS-1 go to STOP with stop_idx=0.
//    - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
//  - Frame length is (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles, measured from the first start-bit cycle.
//  - tx_ready rises on the cycle after the last stop-bit cycle.
//    Minimum accept-to-accept spacing is frame length + 1 cycle; this is the back-to-back case.
//  - tx_valid while busy: ignored, and no byte is lost. The host must hold tx_valid until it sees an accept.
//  - tx_data changes after accept: no effect on the frame in flight.
//  - tx is driven from a register (no combinational path to the pin), so it is glitch-free.
//  - Reset mid-frame: the frame aborts. From the next cycle tx=1 and the block is in IDLE.
//    No partial bits resume after reset releases.
//  - reset and tx_valid high together: reset wins; no accept.
//  - Counter widths: baud counter is $clog2(CLKS_PER_BIT) bits; bit counter is $clog2(DATA_BITS) bits.
//    There is no wrap-around beyond the terminal counts.
// STRUCTURE
//  - Shared include uart_defs.vh: state encodings (IDLE=0, START=1, DATA=2, STOP=3), IDLE_LEVEL=1.
//    This file also holds the default CLKS_PER_BIT, so both directions of the link agree on the bit period.
//  - Sub-module tx_baud_tick: counter with a synchronous clear input (driven by accept), CLKS_PER_BIT parameter and a one-cycle tick output.
//    It is kept separate from the existing receive-side baud logic because its clear-on-accept phase alignment differs.
//  - Top level: FSM, shift register, bit/stop counters and output register.
// TESTING  (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated)
//  - Reset held 3 cycles, then released with tx_valid=0:
//    tx=1, tx_ready=1, busy=0, baud=0 for 50 cycles.
//  - Send 0xA5:
//    tx per bit = 0, 1,0,1,0,0,1,0,1, 1.
//    Each bit lasts exactly 4 cycles; start bit begins 1 cycle after accept; tx_ready=1 again 41 cycles after accept.
//  - Back-to-back 0x00 then 0xFF with tx_valid held high:
//    second accept occurs exactly 41 cycles after the first; tx never glitches between frames.
//  - Change tx_data to 0x3C one cycle after accepting 0x81:
//    the line carries 0x81; the 0x3C is not accepted until tx_ready.
//  - Assert reset during DATA bit 3:
//    next cycle tx=1 and tx_ready=1; a following send of 0x5A produces one clean frame.
//  - Loopback into the receiver with STOP_BITS=2 and CLKS_PER_BIT=16:
//    random 256 bytes are received intact, and frame length is 176 cycles.

Source files
------------

// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmit path: state encodings, line idle level
// and the default bit period, so both link directions agree on timing.
package uart_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic IDLE_LEVEL           = 1'b1;
  localparam int   DEFAULT_CLKS_PER_BIT = 16;

endpackage

// File: rtl/tx_baud_tick.sv
// Bit-period counter for the transmitter. Phase is aligned to the frame: it is
// cleared on accept and only counts while a frame is in progress.
module tx_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == TERMINAL) ? '0 : count + 1'b1;
    end else begin
      count <= '0;
    end
  end

  assign tick = enable && (count == TERMINAL);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: accepts one word per valid/ready handshake and serialises it as
// start bit, data LSB-first, then stop bit(s), with tx driven from a register.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 baud,
  output tx_state_e            state
);

  // Handshake: a word transfers on a rising clk edge where tx_valid and tx_ready are
  // both high; tx_ready is high only in IDLE, and tx_valid must stay up until then.

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  tx_state_e            state_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [BW-1:0]        bit_idx, bit_idx_next;
  logic                 stop_idx, stop_idx_next;
  logic                 tx_next;
  logic                 accept;
  logic                 tick;

  assign accept = tx_valid && (state == IDLE);

  tx_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .enable(state != IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    bit_idx_next  = bit_idx;
    stop_idx_next = stop_idx;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_next    = START;
          shreg_next    = tx_data;
          bit_idx_next  = '0;
          stop_idx_next = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_next   = DATA;
          bit_idx_next = '0;
        end
      end
      DATA: begin
        if (tick) begin
          shreg_next = shreg >> 1;
          if (bit_idx == LAST_BIT) begin
            state_next    = STOP;
            stop_idx_next = 1'b0;
          end else begin
            bit_idx_next = bit_idx + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_idx == LAST_STOP) begin
            state_next = IDLE;
          end else begin
            stop_idx_next = stop_idx + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The line level is decided from the next state so the pin itself is a flop.
  always_comb begin
    tx_next = IDLE_LEVEL;
    case (state_next)
      START:   tx_next = ~IDLE_LEVEL;
      DATA:    tx_next = shreg_next[0];
      default: tx_next = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      tx       <= IDLE_LEVEL;
    end else begin
      state    <= state_next;
      shreg    <= shreg_next;
      bit_idx  <= bit_idx_next;
      stop_idx <= stop_idx_next;
      tx       <= tx_next;
    end
  end

  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;
  assign baud     = tick;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: a cycle-level waveform model for a CPB=4 instance and
// a mid-bit sampling receiver for a CPB=16, two-stop-bit loopback instance.
module tb_uart_transmitter;
  import uart_transmitter_pkg::*;

  localparam int CPB_A = 4;
  localparam int DB    = 8;
  localparam int CPB_B = 16;
  localparam int SB_B  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_valid_a, tx_valid_b;
  logic       tx_ready_a, tx_a, busy_a, baud_a;
  logic       tx_ready_b, tx_b, busy_b, baud_b;
  tx_state_e  state_a, state_b;

  uart_transmitter #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(DB), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .tx(tx_a), .busy(busy_a), .baud(baud_a), .state(state_a)
  );

  uart_transmitter #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(DB), .STOP_BITS(SB_B)) dut_b (
    .clk(clk), .reset(reset), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx(tx_b), .busy(busy_b), .baud(baud_b), .state(state_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- model for instance A ----------------
  // Each queue entry is one clock interval of the line: {baud, tx}.
  logic [1:0] exp_q[$];
  logic [1:0] cur_exp = 2'b01;
  logic       m_ready = 1'b0;
  logic       m_live  = 1'b0;

  function automatic void push_frame(input logic [7:0] d);
    logic bit_val;
    for (int b = 0; b < DB + 2; b++) begin
      if (b == 0)       bit_val = 1'b0;
      else if (b <= DB) bit_val = d[b-1];
      else              bit_val = 1'b1;
      for (int c = 0; c < CPB_A; c++) exp_q.push_back({(c == CPB_A - 1), bit_val});
    end
  endfunction

  initial begin : model_a
    forever begin
      @(posedge clk);
      cyc++;
      if (reset === 1'b1) begin
        exp_q.delete();
        m_ready = 1'b1;
        cur_exp = 2'b01;
        m_live  = 1'b1;
      end else if (m_live) begin
        if (m_ready && tx_valid_a) push_frame(tx_data_a);
        if (exp_q.size() > 0) begin
          cur_exp = exp_q.pop_front();
          m_ready = 1'b0;
        end else begin
          cur_exp = 2'b01;
          m_ready = 1'b1;
        end
      end
    end
  end

  initial begin : compare_a
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("tx_a", tx_a, cur_exp[0]);
        check("baud_a", baud_a, cur_exp[1]);
        check("tx_ready_a", tx_ready_a, m_ready);
        check("busy_a", busy_a, !m_ready);
        check("idle_state_a", state_a == IDLE, m_ready);
      end
    end
  end

  // ---------------- receiver / scoreboard for instance B ----------------
  logic [7:0] exp_b[$];

  initial begin : rx_b
    logic [7:0] rb;
    int len;
    forever begin
      @(negedge clk);
      if (tx_b === 1'b0) begin
        repeat (CPB_B / 2) @(negedge clk);
        check("rx_start_b", tx_b, 0);
        check("rx_start_state_b", state_b, START);
        check("rx_busy_b", busy_b, 1);
        check("rx_baud_mid_b", baud_b, 0);
        for (int i = 0; i < DB; i++) begin
          repeat (CPB_B) @(negedge clk);
          rb[i] = tx_b;
        end
        for (int s = 0; s < SB_B; s++) begin
          repeat (CPB_B) @(negedge clk);
          check("rx_stop_b", tx_b, 1);
        end
        if (exp_b.size() == 0) fail_now("rx_unexpected_frame_b");
        else check("rx_byte_b", rb, exp_b.pop_front());
        len = CPB_B / 2 + (DB + SB_B) * CPB_B;
        while (tx_ready_b !== 1'b1 && len < 400) begin
          @(negedge clk);
          len++;
        end
        check("frame_len_b", len, 176);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_a(input logic [7:0] d, input bit keep, output int acc_cyc);
    bit done = 0;
    bit rdy;
    int waited = 0;
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    while (!done && waited < 200) begin
      @(negedge clk);
      rdy = (tx_ready_a === 1'b1) && (reset === 1'b0);
      @(posedge clk);
      #1;
      if (rdy) done = 1;
      else waited++;
    end
    acc_cyc = cyc;
    if (!done) fail_now("send_a_timeout");
    if (!keep) tx_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input bit keep);
    bit done = 0;
    bit rdy;
    int waited = 0;
    tx_data_b  = d;
    tx_valid_b = 1'b1;
    while (!done && waited < 400) begin
      @(negedge clk);
      rdy = (tx_ready_b === 1'b1) && (reset === 1'b0);
      @(posedge clk);
      #1;
      if (rdy) done = 1;
      else waited++;
    end
    if (done) exp_b.push_back(d);
    else fail_now("send_b_timeout");
    if (!keep) tx_valid_b = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int acc1, acc2, rst_cyc, w;
    logic [9:0] a5_line;
    a5_line    = 10'b1101001010;
    reset      = 1'b1;
    tx_valid_a = 1'b0;
    tx_valid_b = 1'b0;
    tx_data_a  = 8'h00;
    tx_data_b  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_tx", tx_a, 1);
      check("idle_ready", tx_ready_a, 1);
      check("idle_busy", busy_a, 0);
      check("idle_baud", baud_a, 0);
      check("idle_state", state_a, IDLE);
      check("idle_tx_b", tx_b, 1);
    end
    @(posedge clk);
    #1;

    // 0xA5 frame sampled at the second cycle of every bit
    send_a(8'hA5, 0, acc1);
    repeat (2) @(negedge clk);
    check("a5_bit0", tx_a, a5_line[0]);
    for (int k = 1; k < 10; k++) begin
      repeat (CPB_A) @(negedge clk);
      check("a5_bit", tx_a, a5_line[k]);
    end
    repeat (2) @(negedge clk);
    check("a5_ready_last_stop", tx_ready_a, 0);
    @(negedge clk);
    check("a5_ready_after", tx_ready_a, 1);
    idle_cycles(5);

    // back-to-back with tx_valid held
    send_a(8'h00, 1, acc1);
    send_a(8'hFF, 0, acc2);
    check("b2b_spacing", acc2 - acc1, 41);
    idle_cycles(45);

    // data changed one cycle after accept
    send_a(8'h81, 0, acc1);
    idle_cycles(1);
    send_a(8'h3C, 0, acc2);
    check("hold_spacing", acc2 - acc1, 41);
    idle_cycles(45);

    // reset during data bit 3, with tx_valid high through the reset cycle
    send_a(8'h33, 0, acc1);
    idle_cycles(17);
    reset      = 1'b1;
    tx_data_a  = 8'h5A;
    tx_valid_a = 1'b1;
    idle_cycles(1);
    reset   = 1'b0;
    rst_cyc = cyc;
    @(negedge clk);
    check("rst_tx", tx_a, 1);
    check("rst_ready", tx_ready_a, 1);
    @(posedge clk);
    #1;
    tx_valid_a = 1'b0;
    // the edge just passed had tx_valid high and ready high, so 0x5A went out there
    check("rst_accept_after", cyc, rst_cyc + 1);
    idle_cycles(45);

    // random traffic on A
    for (int i = 0; i < 8; i++) begin
      idle_cycles($urandom_range(0, 5));
      send_a(8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), acc1);
    end
    tx_valid_a = 1'b0;
    idle_cycles(45);

    // loopback stream on B
    for (int i = 0; i < 256; i++) begin
      send_b(8'($urandom_range(0, 255)), (i < 255) && ($urandom_range(0, 1) == 1));
      if (tx_valid_b == 1'b0) idle_cycles($urandom_range(0, 3));
    end
    w = 0;
    while (exp_b.size() > 0 && w < 1000) begin
      @(posedge clk);
      w++;
    end
    check("rx_drain_b", exp_b.size(), 0);
    idle_cycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1500000;
    fail_now("watchdog_timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
